// File: rtl/moore_pkg.sv
// rtl/moore_pkg.sv - shared codes and state type for the Moore-FSM steering driver
package moore_pkg;

    localparam logic [1:0] ST_A = 2'b00;
    localparam logic [1:0] ST_B = 2'b01;
    localparam logic [1:0] ST_C = 2'b10;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_BADCMD  = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;
    localparam logic [1:0] RSP_UNEXP   = 2'b11;

    typedef enum logic [2:0] {
        DRV_IDLE,
        DRV_ENTER,
        DRV_HOLD,
        DRV_RELEASE,
        DRV_DONE
    } drv_state_e;

    function automatic logic legal_target(input logic [1:0] t);
        return (t == ST_B) || (t == ST_C);
    endfunction

endpackage

// File: rtl/moore_drv_timer.sv
// rtl/moore_drv_timer.sv - restartable saturating up-counter with expiry flag
module moore_drv_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         restart_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W-1:0] count_now;

    // restart_i marks the first cycle of a state, so that cycle reads as count 0
    assign count_now = restart_i ? '0 : count_q;
    assign expired_o = (count_now >= limit_i);
    assign count_d   = (count_now == '1) ? count_now : count_now + W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/moore_state_driver.sv
// rtl/moore_state_driver.sv - steers a two-bit Moore FSM into a commanded state, holds, releases, reports
// Optional statistics ports enabled by MOORE_DRV_STATS_EN.
module moore_state_driver
    import moore_pkg::*;
#(
    parameter int HOLD_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_target,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              x,
    output logic              y,
    input  logic [1:0]        z,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_code
`ifdef MOORE_DRV_STATS_EN
    ,
    output logic [7:0]        txn_count,
    output logic [7:0]        err_count
`endif
);

    localparam int              TMO_W     = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT - 1);

    drv_state_e        state_q;
    logic [1:0]        target_q;
    logic [HOLD_W-1:0] hold_q;
    logic [1:0]        code_q;
    logic              pre_q;
    logic              entry_q;
    logic              tmo_expired;
    logic              hold_expired;

    moore_drv_timer #(.W(TMO_W)) u_tmo (
        .clk       (clk),
        .reset     (reset),
        .restart_i (entry_q),
        .limit_i   (TMO_LIMIT),
        .expired_o (tmo_expired)
    );

    moore_drv_timer #(.W(HOLD_W)) u_hold (
        .clk       (clk),
        .reset     (reset),
        .restart_i (entry_q),
        .limit_i   (hold_q - HOLD_W'(1)),
        .expired_o (hold_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= DRV_IDLE;
            target_q <= ST_A;
            hold_q   <= HOLD_W'(1);
            code_q   <= RSP_OK;
            pre_q    <= 1'b0;
            entry_q  <= 1'b0;
        end else begin
            entry_q <= 1'b0;
            case (state_q)
                DRV_IDLE: begin
                    if (cmd_valid) begin
                        target_q <= cmd_target;
                        hold_q   <= (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
                        code_q   <= RSP_OK;
                        entry_q  <= 1'b1;
                        pre_q    <= 1'b0;
                        if (!legal_target(cmd_target)) begin
                            code_q  <= RSP_BADCMD;
                            state_q <= DRV_DONE;
                        end else if (z != ST_A) begin
                            // FSM not parked in A: walk it home before steering
                            pre_q   <= 1'b1;
                            state_q <= DRV_RELEASE;
                        end else begin
                            state_q <= DRV_ENTER;
                        end
                    end
                end
                DRV_ENTER: begin
                    if (z == target_q) begin
                        state_q <= DRV_HOLD;
                        entry_q <= 1'b1;
                    end else if (tmo_expired) begin
                        code_q  <= RSP_TIMEOUT;
                        state_q <= DRV_RELEASE;
                        entry_q <= 1'b1;
                    end
                end
                DRV_HOLD: begin
                    if (z != target_q) begin
                        code_q  <= RSP_UNEXP;
                        state_q <= DRV_RELEASE;
                        entry_q <= 1'b1;
                    end else if (hold_expired) begin
                        state_q <= DRV_RELEASE;
                        entry_q <= 1'b1;
                    end
                end
                DRV_RELEASE: begin
                    if (z == ST_A) begin
                        entry_q <= 1'b1;
                        pre_q   <= 1'b0;
                        state_q <= pre_q ? DRV_ENTER : DRV_DONE;
                    end else if (tmo_expired) begin
                        if (code_q == RSP_OK) begin
                            code_q <= RSP_TIMEOUT;
                        end
                        pre_q   <= 1'b0;
                        state_q <= DRV_DONE;
                    end
                end
                DRV_DONE: begin
                    if (rsp_ready) begin
                        state_q <= DRV_IDLE;
                    end
                end
                default: state_q <= DRV_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == DRV_IDLE);
    assign rsp_valid = (state_q == DRV_DONE);
    assign rsp_code  = code_q;
    assign x         = (state_q == DRV_ENTER) || (state_q == DRV_HOLD);
    assign y         = x & target_q[1];

`ifdef MOORE_DRV_STATS_EN
    logic [7:0] txn_q;
    logic [7:0] err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txn_q <= 8'd0;
            err_q <= 8'd0;
        end else if (rsp_valid && rsp_ready) begin
            if (txn_q != 8'hff) begin
                txn_q <= txn_q + 8'd1;
            end
            if ((code_q != RSP_OK) && (err_q != 8'hff)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign txn_count = txn_q;
    assign err_count = err_q;
`endif

endmodule
